horner_seq_ctrl: RTL and testbench

HORNER_SEQ_CTRL -- requirements
Module: horner_seq_ctrl

---
 rtl/horner_seq_ctrl.sv | 150 +++++++++++++++
 tb/tb_horner_seq_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/horner_seq_ctrl.sv
// Sequencer for a Horner-scheme polynomial evaluator: walks D coefficient steps per
// sample, waits out the MAC datapath after each step, and hands results downstream.
module horner_seq_ctrl #(
    parameter int ADDR_LINES  = 4,
    parameter int CNT_W       = 8,
    parameter int MAC_LATENCY = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_LINES-1:0] wr_ptr_coeff,
    input  logic [CNT_W-1:0]      sample_count,
    input  logic                  start_signal,
    input  logic                  start_coeff,
    input  logic                  out_ready,
    input  logic                  abort,
    output logic                  wr_en_signal,
    output logic                  wr_en_coeff,
    output logic                  rd_en_signal,
    output logic                  rd_en_coeff,
    output logic [ADDR_LINES-1:0] coeff_addr,
    output logic                  redo_coeff,
    output logic                  redo_data,
    output logic                  LD_result,
    output logic                  busy,
    output logic                  done
);

    localparam int WAIT_W = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAC_LATENCY - 1);

    typedef enum logic [2:0] {
        ST_LOAD   = 3'd0,
        ST_PRIME  = 3'd1,
        ST_CHECK  = 3'd2,
        ST_STEP   = 3'd3,
        ST_WAIT   = 3'd4,
        ST_RESULT = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_LINES-1:0] deg_q, deg_d;
    logic [ADDR_LINES-1:0] k_q, k_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic [CNT_W-1:0]      rem_q, rem_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LOAD;
            deg_q   <= '0;
            k_q     <= '0;
            wait_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            deg_q   <= deg_d;
            k_q     <= k_d;
            wait_q  <= wait_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        deg_d        = deg_q;
        k_d          = k_q;
        wait_d       = wait_q;
        rem_d        = rem_q;
        wr_en_signal = 1'b0;
        wr_en_coeff  = 1'b0;
        rd_en_signal = 1'b0;
        rd_en_coeff  = 1'b0;
        coeff_addr   = '0;
        redo_coeff   = 1'b0;
        redo_data    = 1'b1;
        LD_result    = 1'b0;
        done         = 1'b0;
        busy         = !rst && (state_q != ST_LOAD);

        if (rst) begin
            // Reset presents LOAD decoding but never launches a batch
            state_d      = ST_LOAD;
            wr_en_signal = !start_signal;
            wr_en_coeff  = start_signal & !start_coeff;
        end else if (abort && (state_q != ST_LOAD)) begin
            state_d = ST_LOAD;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    wr_en_signal = !start_signal;
                    wr_en_coeff  = start_signal & !start_coeff;
                    if (start_signal && start_coeff && !abort) begin
                        deg_d = wr_ptr_coeff;
                        rem_d = sample_count;
                        if (sample_count == '0) begin
                            state_d = ST_DONE;
                        end else begin
                            rd_en_signal = 1'b1;
                            redo_coeff   = 1'b1;
                            state_d      = ST_PRIME;
                        end
                    end
                end
                ST_PRIME: begin
                    redo_data = 1'b0;
                    k_d       = deg_q;
                    state_d   = ST_CHECK;
                end
                ST_CHECK: begin
                    state_d = (k_q == '0) ? ST_RESULT : ST_STEP;
                end
                ST_STEP: begin
                    rd_en_coeff = 1'b1;
                    coeff_addr  = k_q - ADDR_LINES'(1);
                    k_d         = k_q - ADDR_LINES'(1);
                    wait_d      = '0;
                    state_d     = ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_q == WAIT_LAST) begin
                        state_d = ST_CHECK;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
                ST_RESULT: begin
                    if (out_ready) begin
                        LD_result = 1'b1;
                        rem_d     = rem_q - CNT_W'(1);
                        if (rem_q == CNT_W'(1)) begin
                            state_d = ST_DONE;
                        end else begin
                            rd_en_signal = 1'b1;
                            redo_coeff   = 1'b1;
                            state_d      = ST_PRIME;
                        end
                    end
                end
                ST_DONE: begin
                    done    = 1'b1;
                    state_d = ST_LOAD;
                end
                default: begin
                    state_d = ST_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_horner_seq_ctrl.sv
// Scoreboard bench for horner_seq_ctrl: expected strobe cycles are derived from the
// latency relation and compared as the sequencer emits them.
module tb_horner_seq_ctrl;

    localparam int L = 12;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] wr_ptr_coeff;
    logic [7:0] sample_count;
    logic       start_signal, start_coeff, out_ready, abort;
    logic       wr_en_signal, wr_en_coeff, rd_en_signal, rd_en_coeff;
    logic [3:0] coeff_addr;
    logic       redo_coeff, redo_data, LD_result, busy, done;

    int n_cmp = 0;
    int n_err = 0;

    horner_seq_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .wr_ptr_coeff (wr_ptr_coeff),
        .sample_count (sample_count),
        .start_signal (start_signal),
        .start_coeff  (start_coeff),
        .out_ready    (out_ready),
        .abort        (abort),
        .wr_en_signal (wr_en_signal),
        .wr_en_coeff  (wr_en_coeff),
        .rd_en_signal (rd_en_signal),
        .rd_en_coeff  (rd_en_coeff),
        .coeff_addr   (coeff_addr),
        .redo_coeff   (redo_coeff),
        .redo_data    (redo_data),
        .LD_result    (LD_result),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [6:0] v;
        rst = 1'b1; abort = 1'b1; start_signal = 1'b1; start_coeff = 1'b1;
        out_ready = 1'b1; wr_ptr_coeff = 4'd3; sample_count = 8'd2;
        tick; tick;
        @(negedge clk);
        v = {busy, done, LD_result, redo_data, rd_en_signal, rd_en_coeff, redo_coeff};
        n_cmp++;
        if (v !== 7'b0001000) begin
            n_err++; $display("FAIL reset_outputs: got %b expected %b", v, 7'b0001000);
        end
        tick;
        rst = 1'b0; abort = 1'b0; start_signal = 1'b0; start_coeff = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, wr_en_signal} !== 2'b01) begin
            n_err++; $display("FAIL reset_release: got %b expected %b", {busy, wr_en_signal}, 2'b01);
        end
        tick;
    endtask

    task automatic test_load_strobes;
        bit seen;
        wr_ptr_coeff = 4'd0; sample_count = 8'd1;
        start_signal = 1'b0; start_coeff = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({wr_en_signal, wr_en_coeff} !== 2'b10) begin
            n_err++; $display("FAIL load_idle: got %b expected %b", {wr_en_signal, wr_en_coeff}, 2'b10);
        end
        tick;
        start_signal = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({wr_en_signal, wr_en_coeff} !== 2'b01) begin
            n_err++; $display("FAIL load_coeff_wr: got %b expected %b", {wr_en_signal, wr_en_coeff}, 2'b01);
        end
        tick;
        start_coeff = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({rd_en_signal, redo_coeff, wr_en_signal, wr_en_coeff, busy} !== 5'b11000) begin
            n_err++; $display("FAIL load_start: got %b expected %b",
                              {rd_en_signal, redo_coeff, wr_en_signal, wr_en_coeff, busy}, 5'b11000);
        end
        tick;
        start_signal = 1'b0; start_coeff = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({rd_en_signal, redo_coeff, busy, redo_data} !== 4'b0010) begin
            n_err++; $display("FAIL prime_decode: got %b expected %b",
                              {rd_en_signal, redo_coeff, busy, redo_data}, 4'b0010);
        end
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick;
            @(negedge clk);
            seen = done;
        end
        n_cmp++;
        if (!seen) begin
            n_err++; $display("FAIL load_batch_done: got 0 expected 1 within 10 cycles");
        end
        tick;
    endtask

    task automatic test_batch(input int d, input int n, input int stall);
        int rds_q[$];
        int rdc_q[$];
        int adr_q[$];
        int ldr_q[$];
        int don_q[$];
        int t, nom, last, e;
        t = 0;
        nom = 3 + d * (L + 2);
        for (int s = 0; s < n; s++) begin
            rds_q.push_back(t);
            for (int j = 0; j < d; j++) begin
                rdc_q.push_back(t + 3 + j * (L + 2));
                adr_q.push_back(d - 1 - j);
            end
            t = t + 3 + d * (L + 2) + ((s == 0) ? stall : 0);
            ldr_q.push_back(t);
        end
        don_q.push_back(t + 1);
        last = t + 1;

        wr_ptr_coeff = 4'(d); sample_count = 8'(n);
        start_signal = 1'b1; start_coeff = 1'b1;
        for (int c = 0; c <= last + 2; c++) begin
            out_ready = !(c >= nom && c < nom + stall);
            @(negedge clk);
            if (rd_en_signal || redo_coeff) begin
                n_cmp++;
                if (rd_en_signal !== redo_coeff) begin
                    n_err++; $display("FAIL redo_coeff_pair: got %b expected %b at cycle %0d",
                                      redo_coeff, rd_en_signal, c);
                end
            end
            if (rd_en_signal) begin
                n_cmp++;
                if (rds_q.size() == 0) begin
                    n_err++; $display("FAIL rd_en_signal_extra: got pulse at cycle %0d expected none", c);
                end else begin
                    e = rds_q.pop_front();
                    if (c !== e) begin
                        n_err++; $display("FAIL rd_en_signal_cycle: got %0d expected %0d", c, e);
                    end
                end
            end
            if (rd_en_coeff) begin
                n_cmp++;
                if (rdc_q.size() == 0) begin
                    n_err++; $display("FAIL rd_en_coeff_extra: got pulse at cycle %0d expected none", c);
                end else begin
                    e = rdc_q.pop_front();
                    t = adr_q.pop_front();
                    if (c !== e || int'(coeff_addr) !== t) begin
                        n_err++; $display("FAIL rd_en_coeff: got cycle %0d addr %0d expected cycle %0d addr %0d",
                                          c, coeff_addr, e, t);
                    end
                end
            end
            if (LD_result) begin
                n_cmp++;
                if (ldr_q.size() == 0) begin
                    n_err++; $display("FAIL ld_result_extra: got pulse at cycle %0d expected none", c);
                end else begin
                    e = ldr_q.pop_front();
                    if (c !== e) begin
                        n_err++; $display("FAIL ld_result_cycle: got %0d expected %0d", c, e);
                    end
                end
            end
            if (done) begin
                n_cmp++;
                if (don_q.size() == 0) begin
                    n_err++; $display("FAIL done_extra: got pulse at cycle %0d expected none", c);
                end else begin
                    e = don_q.pop_front();
                    if (c !== e) begin
                        n_err++; $display("FAIL done_cycle: got %0d expected %0d", c, e);
                    end
                end
            end
            tick;
            if (c == 0) begin
                start_signal = 1'b0; start_coeff = 1'b0;
                wr_ptr_coeff = 4'hf; sample_count = 8'hff;
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        e = rds_q.size() + rdc_q.size() + ldr_q.size() + don_q.size();
        if (e != 0 || busy !== 1'b0) begin
            n_err++; $display("FAIL batch_end d=%0d n=%0d: got %0d missing events busy=%b expected 0 and 0",
                              d, n, e, busy);
        end
        tick;
    endtask

    task automatic test_abort;
        logic [7:0] v;
        int bad;
        // abort while waiting on the MAC
        wr_ptr_coeff = 4'd2; sample_count = 8'd2; out_ready = 1'b1;
        start_signal = 1'b1; start_coeff = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            if (c == 5) abort = 1'b1;
            @(negedge clk);
            if (c == 5) begin
                v = {wr_en_signal, wr_en_coeff, rd_en_signal, rd_en_coeff, redo_coeff, redo_data, LD_result, done};
                n_cmp++;
                if (v !== 8'b00000100) begin
                    n_err++; $display("FAIL abort_wait_strobes: got %b expected %b", v, 8'b00000100);
                end
            end
            tick;
            if (c == 0) begin start_signal = 1'b0; start_coeff = 1'b0; end
        end
        abort = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL abort_wait_load: got busy=%b expected 0", busy);
        end
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick;
            @(negedge clk);
            if (rd_en_signal || rd_en_coeff || LD_result || done) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++; $display("FAIL abort_wait_quiet: got %0d strobe cycles expected 0", bad);
        end
        tick;

        // abort in RESULT beats the result load
        wr_ptr_coeff = 4'd0; sample_count = 8'd1;
        start_signal = 1'b1; start_coeff = 1'b1;
        for (int c = 0; c <= 3; c++) begin
            if (c == 3) abort = 1'b1;
            @(negedge clk);
            if (c == 3) begin
                n_cmp++;
                if ({LD_result, done, rd_en_signal} !== 3'b000) begin
                    n_err++; $display("FAIL abort_result: got %b expected %b", {LD_result, done, rd_en_signal}, 3'b000);
                end
            end
            tick;
            if (c == 0) begin start_signal = 1'b0; start_coeff = 1'b0; end
        end
        abort = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy || LD_result || done) bad++;
            tick;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++; $display("FAIL abort_result_quiet: got %0d busy/strobe cycles expected 0", bad);
        end

        // abort in LOAD holds off the start
        wr_ptr_coeff = 4'd1; sample_count = 8'd1;
        start_signal = 1'b1; start_coeff = 1'b1; abort = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({rd_en_signal, redo_coeff} !== 2'b00) begin
            n_err++; $display("FAIL abort_load_start: got %b expected %b", {rd_en_signal, redo_coeff}, 2'b00);
        end
        tick;
        start_signal = 1'b0; start_coeff = 1'b0; abort = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL abort_load_busy: got %b expected 0", busy);
        end
        tick;
    endtask

    task automatic test_reset_mid;
        logic [4:0] v;
        int bad;
        wr_ptr_coeff = 4'd1; sample_count = 8'd2; out_ready = 1'b1;
        start_signal = 1'b1; start_coeff = 1'b1;
        for (int c = 0; c <= 3; c++) begin
            if (c == 3) rst = 1'b1;
            @(negedge clk);
            if (c == 3) begin
                v = {rd_en_coeff, busy, LD_result, done, redo_data};
                n_cmp++;
                if (v !== 5'b00001) begin
                    n_err++; $display("FAIL reset_step_strobes: got %b expected %b", v, 5'b00001);
                end
            end
            tick;
            if (c == 0) begin start_signal = 1'b0; start_coeff = 1'b0; end
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL reset_step_load: got busy=%b expected 0", busy);
        end
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            tick;
            @(negedge clk);
            if (busy || rd_en_signal || rd_en_coeff || LD_result || done) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++; $display("FAIL reset_step_quiet: got %0d busy/strobe cycles expected 0", bad);
        end
        tick;
    endtask

    initial begin
        test_reset;
        test_load_strobes;
        test_batch(3, 1, 0);
        test_batch(2, 3, 0);
        test_batch(1, 2, 5);
        test_batch(0, 3, 0);
        test_batch(2, 0, 0);
        test_abort;
        test_batch(2, 2, 0);
        test_reset_mid;
        test_batch(1, 3, 2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
